// File: rtl/cmd_sequencer_if.sv
// Command memory read port plus UART TX FIFO write side, seen from the sequencer (master)
// and from the memory/FIFO pair (slave).
interface cmd_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 10
);
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  tx_wr_en;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_full;

    modport master (
        output mem_rd_en, mem_addr, tx_wr_en, tx_data,
        input  mem_rd_data, tx_full
    );

    modport slave (
        input  mem_rd_en, mem_addr, tx_wr_en, tx_data,
        output mem_rd_data, tx_full
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Replays stored commands from the command memory into the UART TX FIFO, one byte per
// read/wait/send triple, with an idle gap after each command.
module cmd_sequencer #(
    parameter int CMD_WIDTH  = 32,
    parameter int CMD_DEPTH  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1000,
    parameter int ADDR_W     = $clog2(CMD_DEPTH*CMD_WIDTH+1),
    localparam int IDX_W     = $clog2(CMD_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             prog_active,
    cmd_sequencer_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] cmd_idx
);
    localparam int I_W = $clog2(CMD_DEPTH+1);
    localparam int J_W = $clog2(CMD_WIDTH+1);
    localparam int G_W = $clog2(GAP_CYCLES+1);

    typedef enum logic [2:0] {
        IDLE, RD_CNT, WAIT_CNT, RD_BYTE, WAIT_BYTE, SEND, GAP, FINISH
    } state_t;

    state_t                state;
    logic [I_W-1:0]        i, n;
    logic [J_W-1:0]        j;
    logic [G_W-1:0]        gap_cnt;
    logic [DATA_WIDTH-1:0] b;
    logic                  kill;

    // Abort and programming both win over any same-cycle write or done pulse.
    assign kill = (state != IDLE) && (abort || prog_active);

    assign busy          = (state != IDLE);
    assign done          = (state == FINISH) && !kill;
    assign bus.mem_rd_en = (state == RD_CNT) || (state == RD_BYTE);
    assign bus.mem_addr  = (state == RD_BYTE)
                         ? ADDR_W'(1) + ADDR_W'(i) * ADDR_W'(CMD_WIDTH) + ADDR_W'(j)
                         : '0;
    assign bus.tx_wr_en  = (state == SEND) && !bus.tx_full && !kill;
    assign bus.tx_data   = b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            i       <= '0;
            n       <= '0;
            j       <= '0;
            gap_cnt <= '0;
            b       <= '0;
            cmd_idx <= '0;
        end else if (kill) begin
            state   <= IDLE;
            i       <= '0;
            n       <= '0;
            j       <= '0;
            gap_cnt <= '0;
            b       <= '0;
            cmd_idx <= '0;
        end else begin
            case (state)
                IDLE:     if (start && !prog_active) state <= RD_CNT;
                RD_CNT:   state <= WAIT_CNT;
                WAIT_CNT: begin
                    n <= (int'(bus.mem_rd_data) >= CMD_DEPTH) ? I_W'(CMD_DEPTH)
                                                              : I_W'(bus.mem_rd_data);
                    if (bus.mem_rd_data == '0) begin
                        state <= FINISH;
                    end else begin
                        i       <= '0;
                        j       <= '0;
                        cmd_idx <= '0;
                        state   <= RD_BYTE;
                    end
                end
                RD_BYTE:  state <= WAIT_BYTE;
                WAIT_BYTE: begin
                    b <= bus.mem_rd_data;
                    // NUL terminates the command without being transmitted.
                    if (bus.mem_rd_data == '0) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        state   <= SEND;
                    end
                end
                SEND: if (!bus.tx_full) begin
                    j <= j + J_W'(1);
                    if (b == DATA_WIDTH'(8'h0A) || j == J_W'(CMD_WIDTH-1)) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        state   <= RD_BYTE;
                    end
                end
                GAP: begin
                    if (gap_cnt == G_W'(GAP_CYCLES-1)) begin
                        i <= i + I_W'(1);
                        if (i + I_W'(1) == n) begin
                            state <= FINISH;
                        end else begin
                            j       <= '0;
                            cmd_idx <= IDX_W'(i + I_W'(1));
                            state   <= RD_BYTE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + G_W'(1);
                    end
                end
                FINISH:   state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: behavioural command memory, TX capture and
// per-feature test tasks.
module tb_cmd_sequencer;
    localparam int CW  = 32;
    localparam int CD  = 16;
    localparam int DW  = 8;
    localparam int GAP = 20;
    localparam int AW  = $clog2(CD*CW+1);

    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, prog_active = 1'b0;
    logic       busy, done;
    logic [3:0] cmd_idx;

    cmd_sequencer_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus();

    cmd_sequencer #(.CMD_WIDTH(CW), .CMD_DEPTH(CD), .DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_active(prog_active),
        .bus(bus.master), .busy(busy), .done(done), .cmd_idx(cmd_idx)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:CW*CD];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, first_wr_cyc = 0, last_wr_cyc = -100000, done_cyc = 0;
    int wr_cnt = 0, done_cnt = 0, gap_viol = 0, full_viol = 0;
    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];
    logic [3:0] idx_hist [$];
    logic [3:0] prev_idx = 4'd0;

    always @(negedge clk) begin
        cyc++;
        if (start) start_cyc = cyc;
        if (bus.tx_wr_en) begin
            if (bus.tx_full) full_viol++;
            if (wr_cnt == 0) first_wr_cyc = cyc;
            tx_q.push_back(bus.tx_data);
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (bus.mem_rd_en && bus.mem_addr > 1 && ((int'(bus.mem_addr) - 1) % CW) == 0
            && (cyc - last_wr_cyc) < GAP) gap_viol++;
        if (cmd_idx != prev_idx) begin idx_hist.push_back(cmd_idx); prev_idx = cmd_idx; end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; gap_viol = 0; full_viol = 0;
        tx_q.delete(); exp_q.delete(); idx_hist.delete();
        prev_idx = cmd_idx;
    endtask

    task automatic clear_mem();
        for (int a = 0; a <= CW*CD; a++) mem[a] = 8'h00;
    endtask

    task automatic load_cmd(input int idx, input string s);
        for (int k = 0; k < s.len(); k++) mem[1 + idx*CW + k] = s[k];
    endtask

    task automatic exp_str(input string s);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    endtask

    function automatic int q_diff();
        int d = 0;
        int m = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        if (tx_q.size() != exp_q.size()) d++;
        for (int k = 0; k < m; k++) if (tx_q[k] !== exp_q[k]) d++;
        return d;
    endfunction

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (busy && k < max) begin step(1); k++; end
        checks++;
        if (busy) begin errors++; $display("FAIL idle_timeout: busy=%b after %0d cycles", busy, max); end
    endtask

    task automatic wait_wr(input int target, input int max);
        int k = 0;
        while (wr_cnt < target && k < max) begin step(1); k++; end
        checks++;
        if (wr_cnt < target) begin errors++; $display("FAIL write_timeout: writes=%0d want %0d", wr_cnt, target); end
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 8'd2;
        load_cmd(0, "AT\015\012");
        load_cmd(1, "AT+X=1\015\012");
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bus.tx_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin errors++;
            $display("FAIL reset_strobes: tx_wr_en=%b mem_rd_en=%b want 0", bus.tx_wr_en, bus.mem_rd_en); end
        checks++; if (bus.mem_addr !== '0 || bus.tx_data !== '0 || cmd_idx !== '0) begin errors++;
            $display("FAIL reset_values: addr=%0d data=%0h idx=%0d want 0", bus.mem_addr, bus.tx_data, cmd_idx); end
        rst = 1'b0;
        step(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        load_basic(); clear_mon();
        exp_str("AT\015\012AT+X=1\015\012");
        pulse_start();
        wait_idle(2000);
        checks++; if (q_diff() != 0) begin errors++; $display("FAIL basic_stream: got %0d bytes, %0d diffs, want 12 bytes", tx_q.size(), q_diff()); end
        checks++; if (first_wr_cyc - start_cyc != 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", first_wr_cyc - start_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        checks++; if (idx_hist.size() != 1 || idx_hist[0] != 4'd1) begin errors++;
            $display("FAIL basic_cmd_idx: got %0d changes want one change to 1", idx_hist.size()); end
        checks++; if (gap_viol != 0 || full_viol != 0) begin errors++;
            $display("FAIL basic_gap: gap_viol=%0d full_viol=%0d want 0", gap_viol, full_viol); end
    endtask

    task automatic test_zero_count();
        clear_mem(); clear_mon();
        pulse_start();
        wait_idle(100);
        checks++; if (wr_cnt != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt); end
        checks++; if (done_cyc - start_cyc != 3) begin errors++; $display("FAIL zero_done_time: got %0d want 3", done_cyc - start_cyc); end
    endtask

    task automatic test_full_slots();
        int d = 0;
        clear_mem(); clear_mon();
        mem[0] = 8'd20;
        for (int a = 1; a <= CW*CD; a++) mem[a] = 8'h41 + 8'(a % 26);
        pulse_start();
        wait_idle(10000);
        checks++; if (wr_cnt != CW*CD) begin errors++; $display("FAIL full_count: got %0d want %0d", wr_cnt, CW*CD); end
        for (int k = 0; k < tx_q.size() && k < CW*CD; k++) if (tx_q[k] !== mem[k+1]) d++;
        checks++; if (d != 0) begin errors++; $display("FAIL full_bytes: got %0d diffs want 0", d); end
        checks++; if (idx_hist.size() != 16 || idx_hist[idx_hist.size()-1] != 4'd15) begin errors++;
            $display("FAIL full_cmd_idx: got %0d changes want 16 ending at 15", idx_hist.size()); end
        checks++; if (gap_viol != 0 || done_cnt != 1) begin errors++;
            $display("FAIL full_gap_done: gap_viol=%0d done=%0d want 0 and 1", gap_viol, done_cnt); end
    endtask

    task automatic test_tx_full();
        int held;
        clear_mem(); clear_mon();
        mem[0] = 8'd1;
        load_cmd(0, "HELLO\012");
        exp_str("HELLO\012");
        pulse_start();
        wait_wr(2, 200);
        bus.tx_full = 1'b1;
        step(50);
        held = wr_cnt;
        bus.tx_full = 1'b0;
        wait_idle(500);
        checks++; if (held != 2) begin errors++; $display("FAIL full_hold_writes: got %0d want 2", held); end
        checks++; if (full_viol != 0) begin errors++; $display("FAIL full_write_while_full: got %0d want 0", full_viol); end
        checks++; if (q_diff() != 0) begin errors++; $display("FAIL full_stream: got %0d bytes, %0d diffs, want 6 bytes", tx_q.size(), q_diff()); end
    endtask

    task automatic test_abort();
        load_basic(); clear_mon();
        pulse_start();
        wait_wr(6, 500);
        step(2);
        abort = 1'b1;
        @(negedge clk);
        checks++; if (bus.tx_wr_en !== 1'b0) begin errors++; $display("FAIL abort_same_cycle_write: got %b want 0", bus.tx_wr_en); end
        step(1);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || cmd_idx !== 4'd0) begin errors++;
            $display("FAIL abort_idle: busy=%b idx=%0d want 0 0", busy, cmd_idx); end
        step(10);
        checks++; if (wr_cnt != 6 || done_cnt != 0) begin errors++;
            $display("FAIL abort_quiet: writes=%0d done=%0d want 6 0", wr_cnt, done_cnt); end
        clear_mon();
        exp_str("AT\015\012AT+X=1\015\012");
        pulse_start();
        wait_idle(2000);
        checks++; if (q_diff() != 0 || done_cnt != 1) begin errors++;
            $display("FAIL abort_restart: got %0d bytes, %0d diffs, done=%0d want 12 0 1", tx_q.size(), q_diff(), done_cnt); end
    endtask

    task automatic test_prog_and_reset();
        load_basic(); clear_mon();
        prog_active = 1'b1;
        pulse_start();
        step(5);
        checks++; if (busy !== 1'b0 || wr_cnt != 0) begin errors++;
            $display("FAIL prog_start_ignored: busy=%b writes=%0d want 0 0", busy, wr_cnt); end
        prog_active = 1'b0;
        pulse_start();
        wait_wr(2, 200);
        prog_active = 1'b1;
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prog_abort_idle: got %b want 0", busy); end
        prog_active = 1'b0;
        step(10);
        checks++; if (wr_cnt != 2 || done_cnt != 0) begin errors++;
            $display("FAIL prog_abort_quiet: writes=%0d done=%0d want 2 0", wr_cnt, done_cnt); end
        pulse_start();
        begin
            int k = 0;
            while (bus.tx_wr_en !== 1'b1 && k < 200) begin step(1); k++; end
        end
        checks++; if (bus.tx_wr_en !== 1'b1) begin errors++; $display("FAIL reset_setup: tx_wr_en=%b want 1", bus.tx_wr_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.tx_wr_en !== 1'b0 || busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL async_reset_strobes: wr=%b busy=%b rd=%b done=%b want 0", bus.tx_wr_en, busy, bus.mem_rd_en, done); end
        checks++; if (bus.tx_data !== '0 || cmd_idx !== '0 || bus.mem_addr !== '0) begin errors++;
            $display("FAIL async_reset_values: data=%0h idx=%0d addr=%0d want 0", bus.tx_data, cmd_idx, bus.mem_addr); end
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        bus.tx_full = 1'b0;
        clear_mem();
        test_reset();
        test_basic();
        test_zero_count();
        test_full_slots();
        test_tx_full();
        test_abort();
        test_prog_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
